// File: rtl/v_div_pkg.sv
// Shared definitions for the packed vector integer divider.
// funct6 encodings, SEW encoding, FSM states and per-SEW lane helpers.
package v_div_pkg;

  localparam logic [5:0] FUNCT6_VDIVU = 6'b100000;
  localparam logic [5:0] FUNCT6_VDIV  = 6'b100001;
  localparam logic [5:0] FUNCT6_VREMU = 6'b100010;
  localparam logic [5:0] FUNCT6_VREM  = 6'b100011;

  typedef enum logic [1:0] {
    SEW_8   = 2'b00,
    SEW_16  = 2'b01,
    SEW_32  = 2'b10,
    SEW_BAD = 2'b11
  } sew_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ITER,
    ST_FIX,
    ST_DONE
  } div_state_e;

  function automatic logic [31:0] sew_mask(input sew_e s);
    case (s)
      SEW_8:   return 32'h0000_00FF;
      SEW_16:  return 32'h0000_FFFF;
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  function automatic logic [4:0] sew_ew_m1(input sew_e s);
    case (s)
      SEW_8:   return 5'd7;
      SEW_16:  return 5'd15;
      default: return 5'd31;
    endcase
  endfunction

  function automatic logic [1:0] sew_last_lane(input sew_e s);
    case (s)
      SEW_8:   return 2'd3;
      SEW_16:  return 2'd1;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/v_div_core.sv
// Radix-2 restoring divider datapath on unsigned magnitudes up to 32 bits.
// One quotient bit per step; the ew input selects which dividend bit feeds the partial remainder.
module v_div_core
  import v_div_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        step,
  input  logic [1:0]  ew,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  logic [31:0] q_r;
  logic [31:0] d_r;
  logic [31:0] r_r;
  logic        msb;
  logic [32:0] r_sh;
  logic [32:0] r_diff;
  logic        ge;

  // Partial remainder stays below the divisor, so 33 bits cover the shifted trial.
  always_comb begin
    msb    = q_r[sew_ew_m1(sew_e'(ew))];
    r_sh   = {r_r, msb};
    r_diff = r_sh - {1'b0, d_r};
    ge     = ~r_diff[32];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_r <= '0;
      d_r <= '0;
      r_r <= '0;
    end else if (load) begin
      q_r <= dividend;
      d_r <= divisor;
      r_r <= '0;
    end else if (step) begin
      r_r <= ge ? r_diff[31:0] : r_sh[31:0];
      q_r <= {q_r[30:0], ge};
    end
  end

  assign quotient  = q_r;
  assign remainder = r_r;

endmodule

// File: rtl/v_div.sv
// SEW-configurable packed vector divider (vdivu/vdiv/vremu/vrem), lanes processed LSB-first.
// Optional V_DIV_EARLY_OUT_EN: special or |divisor|>|dividend| lanes skip the iteration phase.
module v_div
  import v_div_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            is_div,
  input  logic [XLEN-1:0] op_A,
  input  logic [XLEN-1:0] op_B,
  input  logic [1:0]      sew,
  input  logic [5:0]      op_instr,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  div_state_e      state;
  logic [XLEN-1:0] a_q, b_q, acc, la_q;
  sew_e            sew_q;
  logic            signed_q, rem_q;
  logic [1:0]      lane_k;
  logic [4:0]      cnt;
  logic            neg_a_q, neg_b_q, dz_q, ovf_q;
`ifdef V_DIV_EARLY_OUT_EN
  logic            small, small_q;
`endif

  logic [XLEN-1:0] mask, raw_a, raw_b, sx_a, sx_b, mag_a, mag_b, min_neg;
  logic [XLEN-1:0] core_q, core_r, q_mag, r_mag, q_fix, r_fix, lane_val, acc_next;
  logic [4:0]      shamt, ew_m1;
  logic            neg_a, neg_b, dz, ovf;

  // Lane extraction for SETUP and sign/special fixup for FIX.
  always_comb begin
    mask    = sew_mask(sew_q);
    ew_m1   = sew_ew_m1(sew_q);
    min_neg = mask ^ (mask >> 1);
    case (sew_q)
      SEW_8:   shamt = {lane_k, 3'b000};
      SEW_16:  shamt = {lane_k[0], 4'b0000};
      default: shamt = 5'd0;
    endcase
    raw_a = (a_q >> shamt) & mask;
    raw_b = (b_q >> shamt) & mask;
    neg_a = signed_q & raw_a[ew_m1];
    neg_b = signed_q & raw_b[ew_m1];
    sx_a  = neg_a ? (raw_a | ~mask) : raw_a;
    sx_b  = neg_b ? (raw_b | ~mask) : raw_b;
    mag_a = neg_a ? -sx_a : sx_a;
    mag_b = neg_b ? -sx_b : sx_b;
    dz    = (raw_b == '0);
    ovf   = signed_q && (raw_a == min_neg) && (raw_b == mask);
`ifdef V_DIV_EARLY_OUT_EN
    small = (mag_b > mag_a);
`endif

    q_mag = core_q & mask;
    r_mag = core_r & mask;
    q_fix = (neg_a_q ^ neg_b_q) ? -q_mag : q_mag;
    r_fix = neg_a_q ? -r_mag : r_mag;
    if (dz_q) begin
      q_fix = mask;
      r_fix = la_q;
    end else if (ovf_q) begin
      q_fix = la_q;
      r_fix = '0;
`ifdef V_DIV_EARLY_OUT_EN
    end else if (small_q) begin
      q_fix = '0;
      r_fix = la_q;
`endif
    end
    lane_val = (rem_q ? r_fix : q_fix) & mask;

    acc_next = acc;
    case (sew_q)
      SEW_8:   acc_next[shamt +: 8]  = lane_val[7:0];
      SEW_16:  acc_next[shamt +: 16] = lane_val[15:0];
      default: acc_next              = lane_val;
    endcase
  end

  v_div_core u_core (
    .clk       (clk),
    .rst       (rst),
    .load      (state == ST_SETUP),
    .step      (state == ST_ITER),
    .ew        (sew_q),
    .dividend  (mag_a),
    .divisor   (mag_b),
    .quotient  (core_q),
    .remainder (core_r)
  );

  // Sequencer: IDLE/DONE accept, then SETUP -> ITER -> FIX per lane.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc      <= '0;
      la_q     <= '0;
      sew_q    <= SEW_8;
      signed_q <= 1'b0;
      rem_q    <= 1'b0;
      lane_k   <= '0;
      cnt      <= '0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      dz_q     <= 1'b0;
      ovf_q    <= 1'b0;
`ifdef V_DIV_EARLY_OUT_EN
      small_q  <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          done  <= 1'b0;
          state <= ST_IDLE;
          if (is_div) begin
            a_q      <= op_A;
            b_q      <= op_B;
            sew_q    <= sew_e'(sew);
            signed_q <= op_instr[0];
            rem_q    <= op_instr[1];
            lane_k   <= '0;
            acc      <= '0;
            if ((sew_e'(sew) == SEW_BAD) || (op_instr[5:2] != FUNCT6_VDIVU[5:2])) begin
              state  <= ST_DONE;
              done   <= 1'b1;
              result <= '0;
            end else begin
              state <= ST_SETUP;
              busy  <= 1'b1;
            end
          end
        end
        ST_SETUP: begin
          la_q    <= raw_a;
          neg_a_q <= neg_a;
          neg_b_q <= neg_b;
          dz_q    <= dz;
          ovf_q   <= ovf;
          cnt     <= '0;
          state   <= ST_ITER;
`ifdef V_DIV_EARLY_OUT_EN
          small_q <= small;
          if (dz || ovf || small) state <= ST_FIX;
`endif
        end
        ST_ITER: begin
          cnt <= cnt + 5'd1;
          if (cnt == ew_m1) state <= ST_FIX;
        end
        ST_FIX: begin
          acc <= acc_next;
          if (lane_k == sew_last_lane(sew_q)) begin
            state  <= ST_DONE;
            result <= acc_next;
            done   <= 1'b1;
            busy   <= 1'b0;
          end else begin
            lane_k <= lane_k + 2'd1;
            state  <= ST_SETUP;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/v_div.md
Name: v_div

Overview:
- Iterative SEW-configurable vector integer divider: the inverse of the packed vector multiplier in the vector coprocessor's execute stage.
- Takes one 32-bit packed element group per operation. Lanes are 4x8, 2x16 or 1x32 bits.
- Lanes are processed sequentially through one shared 32-bit radix-2 restoring core.
- Produces quotient or remainder (RVV vdivu/vdiv/vremu/vrem) with a start/busy/done handshake to the vector issue logic.

Parameters:
- XLEN, 32, packed operand/result width; only 32 is supported.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset.
- is_div  in  1  start request; sampled only while busy=0.
- op_A  in  32  dividend group (vs2).
- op_B  in  32  divisor group (vs1).
- sew  in  2  00=8b, 01=16b, 10=32b, 11=illegal.
- op_instr  in  6  funct6: 100000 vdivu, 100001 vdiv, 100010 vremu, 100011 vrem.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse when result is valid.
- result  out  32  packed quotient/remainder; held until the next accepted start.

Behaviour:
- Reset:
  - Single clock; reset is synchronous and active-high.
  - Reset forces busy=0, done=0, result=0 and FSM=IDLE.
  - Reset mid-operation aborts the operation; no done pulse follows.
- Acceptance and operand capture:
  - Accept on is_div=1 && busy=0.
  - op_A, op_B, sew and op_instr are latched on the accepting edge.
  - Inputs are ignored while busy=1.
- FSM states: IDLE -> SETUP -> ITER -> FIX -> (SETUP for next lane | DONE) -> IDLE.
  - SETUP (1 cycle): extract lane k (k=0 first, LSB lane). Sign-extend for signed ops, zero-extend for unsigned. Take magnitudes. Flag div-by-zero (divisor==0) and overflow (signed, dividend==most-negative, divisor==-1).
  - ITER (EW cycles, EW=8/16/32): one restoring shift-subtract step per cycle on EW-bit magnitudes.
  - FIX (1 cycle):
    - Apply signs: quotient negated if signs differ; remainder takes dividend sign.
    - Apply special cases. Div-by-zero: quotient=all ones, remainder=dividend. Overflow: quotient=dividend, remainder=0.
    - Write the EW-bit lane into the result accumulator at bits [k*EW +: EW].
  - DONE: result register updated, done=1 for exactly one cycle, busy=0.
- busy=1 from the cycle after acceptance until the DONE cycle, exclusive.
- Latency from the accept edge to the done pulse is lanes*(EW+2)+1 cycles: sew=10 -> 35, sew=01 -> 37, sew=00 -> 41.
- A new is_div is accepted in the DONE cycle itself; there are no back-to-back bubbles beyond that.
- sew=11 or an unsupported op_instr: accepted, result=0, done pulses 1 cycle after acceptance.
- All arithmetic is per-lane modulo 2^EW; no carries cross lane boundaries.

Optional Feature:
- Macro: V_DIV_EARLY_OUT_EN.
- Defined: a lane flagged div-by-zero or overflow in SETUP, or with |divisor| > |dividend|, skips ITER and goes directly to FIX (2 cycles for that lane). Quotient becomes 0 and remainder becomes the dividend for the magnitude case. Latency becomes data-dependent; done still marks completion.
- Undefined: every lane always takes EW+2 cycles (constant latency as above).

Decomposition:
- Package v_div_pkg holds:
  - funct6 localparams (FUNCT6_VDIVU/VDIV/VREMU/VREM);
  - SEW encoding enum sew_e;
  - FSM enum div_state_e.
- Sub-module v_div_core: 32-bit restoring iteration datapath with load, step and EW inputs; outputs quotient and remainder magnitudes. v_div owns the FSM, lane sequencing, sign/special fixup and handshake.

Test Plan:
1. sew=10, vdivu, op_A=100, op_B=7 -> result=0x0000000E; done exactly 35 cycles after accept; busy high throughout.
2. sew=10, op_A=0xFFFFFFF9 (-7), op_B=2 -> vdiv result=0xFFFFFFFD (-3); vrem result=0xFFFFFFFF (-1).
3. sew=00, vdiv, op_A=0x8010F964, op_B=0xFF030200 -> result=0x8005FDFF (lane0 div0->FF, lane1 -7/2=FD, lane2 16/3=05, lane3 overflow->80); done at cycle 41.
4. sew=01, vremu, op_A=0x00091234, op_B=0x00040000 -> result=0x00011234 (lane1 9%4=1, lane0 rem-by-zero=dividend); done at cycle 37.
5. rst asserted at cycle 10 of a sew=10 op -> next cycle busy=0, result=0, no done pulse. A second is_div asserted while busy is ignored, and the original result is unchanged.
6. sew=11 or op_instr=000000 with is_div=1 -> done one cycle later, result=0. With V_DIV_EARLY_OUT_EN, sew=10 div-by-zero completes in 3 cycles with result=0xFFFFFFFF.
